reg_wb_arb: RTL and testbench

REG_WB_ARB -- requirements
Module: reg_wb_arb

---
 rtl/reg_wb_arb_if.sv | 14 +
 rtl/reg_wb_arb.sv | 86 ++++++++
 tb/tb_reg_wb_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arb_if.sv
// Writeback requester handshake: one instance per requester (ALU, load).
`ifndef FULLW
`define FULLW 32
`endif

interface reg_wb_arb_if #(parameter int ADDR_WIDTH = 4);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [`FULLW-1:0]     data;
    logic                  ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/reg_wb_arb.sv
// Round-robin arbiter for two register-file writeback requesters, with a
// pending-write scoreboard that drives the decode hazard stall.
`ifndef FULLW
`define FULLW 32
`endif

module reg_wb_arb #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    reg_wb_arb_if.slave                a_if,
    reg_wb_arb_if.slave                m_if,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_addr,
    input  logic [ADDR_WIDTH-1:0]      hz_in1,
    input  logic [ADDR_WIDTH-1:0]      hz_in2,
    output logic                       stall,
    output logic                       we,
    output logic [ADDR_WIDTH-1:0]      wa,
    output logic [`FULLW-1:0]          wd,
    output logic                       pc_wr,
    output logic [(1<<ADDR_WIDTH)-1:0] pend
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(15);

    logic                  last_m_q;
    logic                  we_q, pc_wr_q;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [`FULLW-1:0]     wd_q;
    logic [NREG-1:0]       pend_q, pend_d;

    logic                  grant_a, grant_m;
    logic                  a_rdy, m_rdy, xfer;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [`FULLW-1:0]     x_data;

    // last_m_q=1 means M won last, so A has priority on the next conflict
    always_comb begin
        grant_a = a_if.valid && (!m_if.valid || last_m_q);
        grant_m = m_if.valid && !grant_a;
        a_rdy   = reset && en && grant_a;
        m_rdy   = reset && en && grant_m;
        xfer    = a_rdy || m_rdy;
        x_addr  = a_rdy ? a_if.addr : m_if.addr;
        x_data  = a_rdy ? a_if.data : m_if.data;
        pend_d  = pend_q;
        if (xfer)
            pend_d[x_addr] = 1'b0;
        // set after clear: a newly issued producer stays outstanding
        if (en && iss_valid)
            pend_d[iss_addr] = 1'b1;
    end

    assign a_if.ready = a_rdy;
    assign m_if.ready = m_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_m_q <= 1'b1;
            we_q     <= 1'b0;
            pc_wr_q  <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            pend_q   <= '0;
        end else begin
            we_q    <= xfer;
            pc_wr_q <= xfer && (x_addr == PC_ADDR);
            pend_q  <= pend_d;
            if (xfer) begin
                wa_q     <= x_addr;
                wd_q     <= x_data;
                last_m_q <= m_rdy;
            end
        end
    end

    assign stall = pend_q[hz_in1] | pend_q[hz_in2];
    assign we    = we_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign pc_wr = pc_wr_q;
    assign pend  = pend_q;
endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed-vector bench for reg_wb_arb: arbitration order, write latency,
// scoreboard set/clear interaction, enable gating and async reset.
`ifndef FULLW
`define FULLW 32
`endif

module tb_reg_wb_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        iss_valid;
    logic [3:0]  iss_addr, hz_in1, hz_in2;
    logic        stall, we, pc_wr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] pend;

    int checks = 0;
    int errors = 0;

    reg_wb_arb_if #(.ADDR_WIDTH(4)) a_if ();
    reg_wb_arb_if #(.ADDR_WIDTH(4)) m_if ();

    reg_wb_arb #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en),
        .a_if(a_if.slave), .m_if(m_if.slave),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .hz_in1(hz_in1), .hz_in2(hz_in2),
        .stall(stall), .we(we), .wa(wa), .wd(wd),
        .pc_wr(pc_wr), .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        av;  logic [3:0] aa;  logic [31:0] ad;
        logic        mv;  logic [3:0] ma;  logic [31:0] md;
        logic        iv;  logic [3:0] ia;
        logic [3:0]  h1;  logic [3:0] h2;
        logic        e_ar; logic e_mr; logic e_st;
        logic        e_we; logic [3:0] e_wa; logic [31:0] e_wd;
        logic        e_pc; logic [15:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic e, input logic av, input logic [3:0] aa, input logic [31:0] ad,
        input logic mv, input logic [3:0] ma, input logic [31:0] md,
        input logic iv, input logic [3:0] ia, input logic [3:0] h1, input logic [3:0] h2,
        input logic ear, input logic emr, input logic est,
        input logic ewe, input logic [3:0] ewa, input logic [31:0] ewd,
        input logic epc, input logic [15:0] epend);
        vec_t v;
        v.en = e; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia; v.h1 = h1; v.h2 = h2;
        v.e_ar = ear; v.e_mr = emr; v.e_st = est;
        v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_pc = epc; v.e_pend = epend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en;
        a_if.valid = v.av; a_if.addr = v.aa; a_if.data = v.ad;
        m_if.valid = v.mv; m_if.addr = v.ma; m_if.data = v.md;
        iss_valid = v.iv; iss_addr = v.ia; hz_in1 = v.h1; hz_in2 = v.h2;
    endtask

    // called one time unit after a posedge
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v);
        #3;
        chk({tag, ".a_ready"}, 32'(a_if.ready), 32'(v.e_ar));
        chk({tag, ".m_ready"}, 32'(m_if.ready), 32'(v.e_mr));
        chk({tag, ".stall"},   32'(stall),      32'(v.e_st));
        @(posedge clk); #1;
        chk({tag, ".we"},    32'(we),    32'(v.e_we));
        chk({tag, ".wa"},    32'(wa),    32'(v.e_wa));
        chk({tag, ".wd"},    wd,         v.e_wd);
        chk({tag, ".pc_wr"}, 32'(pc_wr), 32'(v.e_pc));
        chk({tag, ".pend"},  32'(pend),  32'(v.e_pend));
    endtask

    initial begin
        //                en av aa  ad          mv ma  md          iv ia  h1 h2   ar mr st  we wa  wd          pc pend
        vecs.push_back(mk(1,1,4'd3,32'h11,      0,4'd0,32'h0,      0,4'd0,4'd0,4'd0, 1,0,0, 1,4'd3,32'h11,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      0,4'd0,4'd0,4'd0, 0,0,0, 0,4'd3,32'h11,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       1,4'd4,32'h44,     0,4'd0,4'd0,4'd0, 0,1,0, 1,4'd4,32'h44,     0,16'h0000));
        vecs.push_back(mk(1,1,4'd1,32'hA1,      1,4'd2,32'hB2,     0,4'd0,4'd0,4'd0, 1,0,0, 1,4'd1,32'hA1,     0,16'h0000));
        vecs.push_back(mk(1,1,4'd1,32'hA1,      1,4'd2,32'hB2,     0,4'd0,4'd0,4'd0, 0,1,0, 1,4'd2,32'hB2,     0,16'h0000));
        vecs.push_back(mk(1,1,4'd1,32'hA1,      1,4'd2,32'hB2,     0,4'd0,4'd0,4'd0, 1,0,0, 1,4'd1,32'hA1,     0,16'h0000));
        vecs.push_back(mk(1,1,4'd1,32'hA1,      1,4'd2,32'hB2,     0,4'd0,4'd0,4'd0, 0,1,0, 1,4'd2,32'hB2,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      0,4'd0,4'd0,4'd0, 0,0,0, 0,4'd2,32'hB2,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      1,4'd5,4'd5,4'd0, 0,0,0, 0,4'd2,32'hB2,     0,16'h0020));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      0,4'd0,4'd5,4'd0, 0,0,1, 0,4'd2,32'hB2,     0,16'h0020));
        vecs.push_back(mk(1,0,4'd0,32'h0,       1,4'd5,32'h55,     0,4'd0,4'd5,4'd0, 0,1,1, 1,4'd5,32'h55,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      0,4'd0,4'd5,4'd0, 0,0,0, 0,4'd5,32'h55,     0,16'h0000));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      1,4'd7,4'd0,4'd0, 0,0,0, 0,4'd5,32'h55,     0,16'h0080));
        vecs.push_back(mk(1,1,4'd7,32'h77,      0,4'd0,32'h0,      1,4'd7,4'd0,4'd7, 1,0,1, 1,4'd7,32'h77,     0,16'h0080));
        vecs.push_back(mk(1,1,4'd7,32'h78,      0,4'd0,32'h0,      1,4'd9,4'd0,4'd0, 1,0,0, 1,4'd7,32'h78,     0,16'h0200));
        vecs.push_back(mk(1,1,4'd6,32'h66,      0,4'd0,32'h0,      0,4'd0,4'd0,4'd0, 1,0,0, 1,4'd6,32'h66,     0,16'h0200));
        vecs.push_back(mk(1,0,4'd0,32'h0,       1,4'd15,32'h40,    0,4'd0,4'd0,4'd0, 0,1,0, 1,4'd15,32'h40,    1,16'h0200));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      0,4'd0,4'd0,4'd0, 0,0,0, 0,4'd15,32'h40,    0,16'h0200));
        vecs.push_back(mk(0,1,4'd1,32'hC1,      1,4'd2,32'hC2,     1,4'd3,4'd9,4'd0, 0,0,1, 0,4'd15,32'h40,    0,16'h0200));
        vecs.push_back(mk(1,1,4'd1,32'hC1,      1,4'd2,32'hC2,     0,4'd0,4'd9,4'd0, 1,0,1, 1,4'd1,32'hC1,     0,16'h0200));
        vecs.push_back(mk(1,1,4'd9,32'h99,      0,4'd0,32'h0,      1,4'd4,4'd0,4'd0, 1,0,0, 1,4'd9,32'h99,     0,16'h0010));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      1,4'd5,4'd0,4'd0, 0,0,0, 0,4'd9,32'h99,     0,16'h0030));
        vecs.push_back(mk(1,0,4'd0,32'h0,       0,4'd0,32'h0,      1,4'd6,4'd0,4'd0, 0,0,0, 0,4'd9,32'h99,     0,16'h0070));
        vecs.push_back(mk(1,1,4'd3,32'h33,      0,4'd0,32'h0,      1,4'd7,4'd0,4'd0, 1,0,0, 1,4'd3,32'h33,     0,16'h00F0));

        reset = 1'b0; en = 1'b0;
        a_if.valid = 1'b1; a_if.addr = 4'd3; a_if.data = 32'h5;
        m_if.valid = 1'b1; m_if.addr = 4'd4; m_if.data = 32'h6;
        iss_valid = 1'b0; iss_addr = '0; hz_in1 = '0; hz_in2 = '0;
        #2;
        en = 1'b1;
        #1;
        chk("rst.we",      32'(we),         32'd0);
        chk("rst.pc_wr",   32'(pc_wr),      32'd0);
        chk("rst.wa",      32'(wa),         32'd0);
        chk("rst.wd",      wd,              32'd0);
        chk("rst.pend",    32'(pend),       32'd0);
        chk("rst.a_ready", 32'(a_if.ready), 32'd0);
        chk("rst.m_ready", 32'(m_if.ready), 32'd0);
        a_if.valid = 1'b0; m_if.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // async reset while a write is on the port and pend=0x00F0
        m_if.valid = 1'b1; m_if.addr = 4'd2; m_if.data = 32'hE2;
        hz_in1 = 4'd4;
        chk("pre_rst.we",   32'(we),   32'd1);
        chk("pre_rst.pend", 32'(pend), 32'h00F0);
        #1 reset = 1'b0;
        #1;
        chk("async_rst.we",      32'(we),         32'd0);
        chk("async_rst.pc_wr",   32'(pc_wr),      32'd0);
        chk("async_rst.wa",      32'(wa),         32'd0);
        chk("async_rst.wd",      wd,              32'd0);
        chk("async_rst.pend",    32'(pend),       32'd0);
        chk("async_rst.stall",   32'(stall),      32'd0);
        chk("async_rst.a_ready", 32'(a_if.ready), 32'd0);
        chk("async_rst.m_ready", 32'(m_if.ready), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        a_if.valid = 1'b1; a_if.addr = 4'd1; a_if.data = 32'hD1;
        m_if.valid = 1'b1; m_if.addr = 4'd2; m_if.data = 32'hD2;
        iss_valid = 1'b0;
        #2;
        chk("post_rst.a_ready", 32'(a_if.ready), 32'd1);
        chk("post_rst.m_ready", 32'(m_if.ready), 32'd0);
        @(posedge clk); #1;
        chk("post_rst.we1", 32'(we), 32'd1);
        chk("post_rst.wa1", 32'(wa), 32'd1);
        chk("post_rst.wd1", wd,      32'hD1);
        #3;
        chk("post_rst.a_ready2", 32'(a_if.ready), 32'd0);
        chk("post_rst.m_ready2", 32'(m_if.ready), 32'd1);
        @(posedge clk); #1;
        chk("post_rst.wa2", 32'(wa), 32'd2);
        chk("post_rst.wd2", wd,      32'hD2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
